// File: rtl/uart_ctrl_if.sv
// CPU-side register bus of uart_ctrl: access strobe, address/data, read-back and interrupt.
interface uart_ctrl_if;
    logic       bus_sel;
    logic       bus_we;
    logic [1:0] bus_addr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       cpu_irq;

    modport master (output bus_sel, bus_we, bus_addr, bus_wdata, input  bus_rdata, cpu_irq);
    modport slave  (input  bus_sel, bus_we, bus_addr, bus_wdata, output bus_rdata, cpu_irq);
endinterface

// File: rtl/uart_ctrl.sv
// UART controller: CPU register bus in front of TX/RX byte FIFOs, with small FSMs
// handshaking bytes to and from a serial-port core.
module uart_ctrl_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees a slot, so a push onto a full FIFO still lands.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

module uart_ctrl #(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    uart_ctrl_if.slave  bus,
    output logic [7:0]  sp_data_in,
    output logic        sp_write_enable,
    input  logic        sp_write_not_busy,
    input  logic [7:0]  sp_data_out,
    input  logic        sp_int_req,
    output logic        sp_int_ack
);
    typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_CAPTURE, RX_ACK} rx_state_t;

    tx_state_t  tx_state, tx_next;
    rx_state_t  rx_state, rx_next;
    logic [1:0] wb_cnt;
    logic       tx_empty, tx_full, rx_empty, rx_full;
    logic [7:0] tx_head, rx_head;
    logic       rx_ie, tx_ie, rx_ovf, tx_busy;
    logic       wr_data, rd_data, wr_ctrl, rx_push, rx_drop;

    assign wr_data = bus.bus_sel &  bus.bus_we & (bus.bus_addr == 2'd0);
    assign rd_data = bus.bus_sel & ~bus.bus_we & (bus.bus_addr == 2'd0);
    assign wr_ctrl = bus.bus_sel &  bus.bus_we & (bus.bus_addr == 2'd2);
    assign rx_push = (rx_state == RX_CAPTURE);
    assign rx_drop = rx_push & rx_full & ~rd_data;
    assign tx_busy = (tx_state != TX_IDLE);

    uart_ctrl_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(wr_data), .pop(tx_state == TX_LOAD),
        .wdata(bus.bus_wdata), .head(tx_head), .empty(tx_empty), .full(tx_full)
    );

    uart_ctrl_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rd_data),
        .wdata(sp_data_out), .head(rx_head), .empty(rx_empty), .full(rx_full)
    );

    always_comb begin
        tx_next         = tx_state;
        sp_write_enable = 1'b0;
        case (tx_state)
            TX_IDLE:      if (!tx_empty && sp_write_not_busy) tx_next = TX_LOAD;
            TX_LOAD: begin
                sp_write_enable = 1'b1;
                tx_next         = TX_WAIT_BUSY;
            end
            // A transmitter that never drops not_busy is assumed done after 4 cycles.
            TX_WAIT_BUSY: if (!sp_write_not_busy) tx_next = TX_WAIT_DONE;
                          else if (wb_cnt == 2'd3) tx_next = TX_IDLE;
            TX_WAIT_DONE: if (sp_write_not_busy) tx_next = TX_IDLE;
            default:      tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_next    = rx_state;
        sp_int_ack = 1'b0;
        case (rx_state)
            RX_IDLE:    if (sp_int_req) rx_next = RX_CAPTURE;
            RX_CAPTURE: rx_next = RX_ACK;
            RX_ACK: begin
                sp_int_ack = 1'b1;
                if (!sp_int_req) rx_next = RX_IDLE;
            end
            default:    rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        bus.bus_rdata = 8'h00;
        case (bus.bus_addr)
            2'd0:    if (!rx_empty) bus.bus_rdata = rx_head;
            2'd1:    bus.bus_rdata = {3'b0, tx_busy, rx_ovf, tx_full, ~rx_empty, tx_empty};
            2'd2:    bus.bus_rdata = {6'b0, tx_ie, rx_ie};
            default: bus.bus_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state    <= TX_IDLE;
            rx_state    <= RX_IDLE;
            wb_cnt      <= 2'd0;
            sp_data_in  <= 8'h00;
            rx_ie       <= 1'b0;
            tx_ie       <= 1'b0;
            rx_ovf      <= 1'b0;
            bus.cpu_irq <= 1'b0;
        end else begin
            tx_state <= tx_next;
            rx_state <= rx_next;
            wb_cnt   <= (tx_state == TX_WAIT_BUSY) ? wb_cnt + 2'd1 : 2'd0;
            if (tx_next == TX_LOAD) sp_data_in <= tx_head;
            if (wr_ctrl) begin
                rx_ie <= bus.bus_wdata[0];
                tx_ie <= bus.bus_wdata[1];
            end
            // Overflow set wins over a same-cycle clear.
            if (rx_drop)                          rx_ovf <= 1'b1;
            else if (wr_ctrl && bus.bus_wdata[2]) rx_ovf <= 1'b0;
            bus.cpu_irq <= (rx_ie & ~rx_empty) | (tx_ie & tx_empty & ~tx_busy) | rx_ovf;
        end
    end
endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl: queue-based reference model, strobe monitor and randomized bus/serial traffic.
module tb_uart_ctrl;
    localparam int TX_DEPTH = 4;
    localparam int RX_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] sp_data_in;
    logic       sp_write_enable;
    logic       sp_write_not_busy;
    logic [7:0] sp_data_out;
    logic       sp_int_req;
    logic       sp_int_ack;

    uart_ctrl_if bus();

    uart_ctrl #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .sp_data_in(sp_data_in), .sp_write_enable(sp_write_enable),
        .sp_write_not_busy(sp_write_not_busy), .sp_data_out(sp_data_out),
        .sp_int_req(sp_int_req), .sp_int_ack(sp_int_ack)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit         ovf_m, rx_ie_m, tx_ie_m;
    bit         hold = 1'b0;
    int         force_busy = 0;
    int         busy_cnt = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h, want %02h", name, act, exp);
        end
    endtask

    // Serial transmitter: after each strobe it stays busy for a random number of cycles (0 = never busy).
    initial begin
        sp_write_not_busy = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) busy_cnt = 0;
            else if (sp_write_enable) busy_cnt = (force_busy != 0) ? force_busy : int'($urandom_range(0, 5));
            else if (busy_cnt > 0) busy_cnt--;
            sp_write_not_busy = !(hold || busy_cnt > 0);
        end
    end

    // Strobe monitor: every transmit strobe must carry the oldest accepted byte.
    initial begin
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (rst && sp_write_enable) begin
                if (tx_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL tx_unexpected_strobe: got data %02h, want no strobe", sp_data_in);
                end else begin
                    exp = tx_q.pop_front();
                    check("tx_strobe_data", sp_data_in, exp);
                end
            end
        end
    end

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        bus.bus_sel = 1'b1; bus.bus_we = 1'b1; bus.bus_addr = a; bus.bus_wdata = d;
        @(negedge clk);
        bus.bus_sel = 1'b0; bus.bus_we = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
        bus.bus_sel = 1'b1; bus.bus_we = 1'b0; bus.bus_addr = a;
        #2 d = bus.bus_rdata;
        @(negedge clk);
        bus.bus_sel = 1'b0;
    endtask

    task automatic tx_push(input logic [7:0] b);
        if (tx_q.size() < TX_DEPTH) tx_q.push_back(b);
        bus_wr(2'd0, b);
    endtask

    task automatic rx_event(input logic [7:0] b);
        int n;
        sp_data_out = b; sp_int_req = 1'b1;
        n = 0;
        while (!sp_int_ack && n < 10) begin @(negedge clk); n++; end
        check("rx_ack_rise", {7'b0, sp_int_ack}, 8'h01);
        sp_int_req = 1'b0;
        n = 0;
        while (sp_int_ack && n < 10) begin @(negedge clk); n++; end
        check("rx_ack_fall", {7'b0, sp_int_ack}, 8'h00);
        if (rx_q.size() < RX_DEPTH) rx_q.push_back(b);
        else ovf_m = 1'b1;
    endtask

    task automatic rd_data_chk(input string name);
        logic [7:0] d, e;
        bus_rd(2'd0, d);
        e = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
        check(name, d, e);
    endtask

    task automatic status_chk(input string name);
        logic [7:0] d, e;
        bus_rd(2'd1, d);
        e = 8'h00;
        e[3] = ovf_m;
        e[1] = (rx_q.size() != 0);
        check(name, d & 8'h0A, e);
    endtask

    task automatic tx_drain(input int limit);
        int n = 0;
        while (tx_q.size() != 0 && n < limit) begin @(negedge clk); n++; end
        check("tx_drain_left", 8'(tx_q.size()), 8'h00);
        repeat (12) @(negedge clk);
    endtask

    initial begin
        logic [7:0] d, x, v;
        bus.bus_sel = 1'b0; bus.bus_we = 1'b0; bus.bus_addr = 2'd1; bus.bus_wdata = 8'h00;
        sp_data_out = 8'h00; sp_int_req = 1'b0;

        #1;
        check("rst_we",     {7'b0, sp_write_enable}, 8'h00);
        check("rst_ack",    {7'b0, sp_int_ack}, 8'h00);
        check("rst_irq",    {7'b0, bus.cpu_irq}, 8'h00);
        check("rst_data",   sp_data_in, 8'h00);
        check("rst_status", bus.bus_rdata, 8'h01);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single byte: strobe in the second cycle after the write edge.
        tx_push(8'h41);
        check("tx_we_cycle1", {7'b0, sp_write_enable}, 8'h00);
        @(negedge clk);
        check("tx_we_cycle2", {7'b0, sp_write_enable}, 8'h01);
        check("tx_data_41",   sp_data_in, 8'h41);
        @(negedge clk);
        check("tx_we_cycle3", {7'b0, sp_write_enable}, 8'h00);
        bus_rd(2'd1, d);
        check("tx_empty_after", d & 8'h01, 8'h01);
        tx_drain(50);

        // Five pushes into a stalled transmitter: the fifth is dropped.
        hold = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 1; i <= 5; i++) tx_push(8'(i));
        bus_rd(2'd1, d);
        check("tx_full", d & 8'h04, 8'h04);
        hold = 1'b0;
        tx_drain(300);

        // Receive one byte: ack two cycles after req, held until req falls.
        sp_data_out = 8'h5A; sp_int_req = 1'b1;
        @(negedge clk); check("ack_c1", {7'b0, sp_int_ack}, 8'h00);
        @(negedge clk); check("ack_c2", {7'b0, sp_int_ack}, 8'h01);
        repeat (2) @(negedge clk);
        check("ack_hold", {7'b0, sp_int_ack}, 8'h01);
        sp_int_req = 1'b0;
        @(negedge clk); check("ack_drop", {7'b0, sp_int_ack}, 8'h00);
        bus_rd(2'd0, d); check("rx_5a", d, 8'h5A);
        bus_rd(2'd0, d); check("rx_empty_rd", d, 8'h00);

        // Overflow: five receives, no reads.
        for (int i = 0; i < 5; i++) rx_event(8'($urandom));
        status_chk("ovf_status");
        @(negedge clk);
        check("ovf_irq", {7'b0, bus.cpu_irq}, 8'h01);
        bus_wr(2'd2, 8'h04);
        ovf_m = 1'b0;
        status_chk("ovf_cleared");
        @(negedge clk);
        check("irq_cleared", {7'b0, bus.cpu_irq}, 8'h00);
        for (int i = 0; i < 5; i++) rd_data_chk("ovf_rd");

        // Full RX FIFO, capture coinciding with a read: pop then push, no overflow.
        for (int i = 0; i < RX_DEPTH; i++) rx_event(8'($urandom));
        x = 8'($urandom);
        sp_data_out = x; sp_int_req = 1'b1;
        @(negedge clk);
        bus.bus_sel = 1'b1; bus.bus_we = 1'b0; bus.bus_addr = 2'd0;
        #2 d = bus.bus_rdata;
        check("coinc_rd", d, rx_q.pop_front());
        @(negedge clk);
        bus.bus_sel = 1'b0;
        check("coinc_ack", {7'b0, sp_int_ack}, 8'h01);
        sp_int_req = 1'b0;
        repeat (2) @(negedge clk);
        rx_q.push_back(x);
        status_chk("coinc_status");
        for (int i = 0; i < RX_DEPTH; i++) rd_data_chk("coinc_drain");

        // Randomized mix of bus and serial-port traffic.
        for (int it = 0; it < 120; it++) begin
            case ($urandom_range(0, 6))
                0: if (tx_q.size() < TX_DEPTH) tx_push(8'($urandom));
                1: rx_event(8'($urandom));
                2: rd_data_chk("rnd_rd");
                3: status_chk("rnd_status");
                4: begin
                    v = 8'($urandom_range(0, 7));
                    bus_wr(2'd2, v);
                    rx_ie_m = v[0]; tx_ie_m = v[1];
                    if (v[2]) ovf_m = 1'b0;
                    bus_rd(2'd2, d);
                    check("rnd_ctrl_rb", d, {6'b0, tx_ie_m, rx_ie_m});
                end
                5: begin
                    bus_wr(2'd3, 8'($urandom));
                    bus_rd(2'd3, d);
                    check("rnd_addr3", d, 8'h00);
                end
                default: if (!tx_ie_m) begin
                    @(negedge clk);
                    check("rnd_irq", {7'b0, bus.cpu_irq},
                          {7'b0, (rx_ie_m && rx_q.size() != 0) || ovf_m});
                end
            endcase
        end
        tx_drain(400);

        // Reset while waiting for the transmitter to finish.
        force_busy = 50;
        tx_push(8'h77);
        tx_drain(50);
        bus.bus_addr = 2'd1;
        #1 check("wd_busy", bus.bus_rdata & 8'h10, 8'h10);
        #1 rst = 1'b0;
        #1;
        check("arst_we",     {7'b0, sp_write_enable}, 8'h00);
        check("arst_ack",    {7'b0, sp_int_ack}, 8'h00);
        check("arst_irq",    {7'b0, bus.cpu_irq}, 8'h00);
        check("arst_data",   sp_data_in, 8'h00);
        check("arst_status", bus.bus_rdata, 8'h01);
        tx_q.delete(); rx_q.delete();
        ovf_m = 1'b0; rx_ie_m = 1'b0; tx_ie_m = 1'b0; force_busy = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        tx_push(8'h99);
        tx_drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
